// File: rtl/cmd_frame_pkg.sv
// Shared constants, encodings and opcode decode helpers for the command frame parser.
package cmd_frame_pkg;

  // Frame opcode bytes
  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    OP_RF_WR   = 2'b00,
    OP_RF_RD   = 2'b01,
    OP_ALU     = 2'b10,
    OP_ALU_NOP = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'b00,
    ERR_OPCODE  = 2'b01,
    ERR_ADDR    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_WDATA = 3'd2,
    ST_GET_OPA   = 3'd3,
    ST_GET_OPB   = 3'd4,
    ST_GET_FUN   = 3'd5,
    ST_HOLD      = 3'd6
  } state_t;

  // True when the byte is one of the four frame opcodes
  function automatic logic opc_known(input logic [7:0] b);
    logic known;
    case (b)
      OPC_WR, OPC_RD, OPC_ALU_OP, OPC_ALU_NOP: known = 1'b1;
      default:                                 known = 1'b0;
    endcase
    return known;
  endfunction

  // First collection state after a given opcode byte
  function automatic state_t opc_next_state(input logic [7:0] b);
    state_t nxt;
    case (b)
      OPC_WR, OPC_RD: nxt = ST_GET_ADDR;
      OPC_ALU_OP:     nxt = ST_GET_OPA;
      OPC_ALU_NOP:    nxt = ST_GET_FUN;
      default:        nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Command type carried by a given opcode byte
  function automatic cmd_op_t opc_to_op(input logic [7:0] b);
    cmd_op_t op;
    case (b)
      OPC_WR:     op = OP_RF_WR;
      OPC_RD:     op = OP_RF_RD;
      OPC_ALU_OP: op = OP_ALU;
      default:    op = OP_ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_timeout_cnt.sv
// Inter-byte silence counter; flags the cycle on which a partial frame must be abandoned.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count silent cycles while a frame is being collected
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // Expiry is the silent cycle that finds the counter already at its last value
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles UART command bytes into a parallel command word with valid/ready handshake
// and one-cycle error pulses for bad opcodes, bad addresses, timeouts and overruns.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Rx_P_Data,
  input  logic                  Rx_D_VLD,
  output logic                  Cmd_Valid,
  input  logic                  Cmd_Ready,
  output logic [1:0]            Cmd_Op,
  output logic [ADDR_WIDTH-1:0] Cmd_Addr,
  output logic [DATA_WIDTH-1:0] Cmd_Data,
  output logic [DATA_WIDTH-1:0] Cmd_OpA,
  output logic [DATA_WIDTH-1:0] Cmd_OpB,
  output logic [3:0]            Cmd_Fun,
  output logic                  Frame_Error,
  output logic [1:0]            Err_Code
);

  state_t  state;
  cmd_op_t pend_op;   // opcode of the frame in progress; published only when complete
  logic    in_get;
  logic    tmo_clear;
  logic    tmo_expired;
  logic    addr_bad;

  assign in_get    = (state != ST_IDLE) && (state != ST_HOLD);
  assign tmo_clear = Rx_D_VLD || !in_get;
  assign addr_bad  = (Rx_P_Data[DATA_WIDTH-1:ADDR_WIDTH] != '0);

  cmd_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RST),
    .clear  (tmo_clear),
    .enable (in_get),
    .expired(tmo_expired)
  );

  // Frame FSM with registered command fields and error pulse
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      pend_op     <= OP_RF_WR;
      Cmd_Valid   <= 1'b0;
      Cmd_Op      <= 2'b00;
      Cmd_Addr    <= '0;
      Cmd_Data    <= '0;
      Cmd_OpA     <= '0;
      Cmd_OpB     <= '0;
      Cmd_Fun     <= 4'h0;
      Frame_Error <= 1'b0;
      Err_Code    <= 2'b00;
    end else begin
      Frame_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Rx_D_VLD) begin
            if (opc_known(Rx_P_Data[7:0])) begin
              state   <= opc_next_state(Rx_P_Data[7:0]);
              pend_op <= opc_to_op(Rx_P_Data[7:0]);
            end else begin
              Frame_Error <= 1'b1;
              Err_Code    <= ERR_OPCODE;
            end
          end
        end
        ST_GET_ADDR: begin
          if (Rx_D_VLD) begin
            if (addr_bad) begin
              Frame_Error <= 1'b1;
              Err_Code    <= ERR_ADDR;
              state       <= ST_IDLE;
            end else begin
              Cmd_Addr <= Rx_P_Data[ADDR_WIDTH-1:0];
              if (pend_op == OP_RF_WR) begin
                state <= ST_GET_WDATA;
              end else begin
                state     <= ST_HOLD;
                Cmd_Valid <= 1'b1;
                Cmd_Op    <= pend_op;
              end
            end
          end else if (tmo_expired) begin
            Frame_Error <= 1'b1;
            Err_Code    <= ERR_TIMEOUT;
            state       <= ST_IDLE;
          end
        end
        ST_GET_WDATA, ST_GET_OPA, ST_GET_OPB, ST_GET_FUN: begin
          if (Rx_D_VLD) begin
            case (state)
              ST_GET_WDATA: begin
                Cmd_Data  <= Rx_P_Data;
                state     <= ST_HOLD;
                Cmd_Valid <= 1'b1;
                Cmd_Op    <= pend_op;
              end
              ST_GET_OPA: begin
                Cmd_OpA <= Rx_P_Data;
                state   <= ST_GET_OPB;
              end
              ST_GET_OPB: begin
                Cmd_OpB <= Rx_P_Data;
                state   <= ST_GET_FUN;
              end
              default: begin
                Cmd_Fun   <= Rx_P_Data[3:0];
                state     <= ST_HOLD;
                Cmd_Valid <= 1'b1;
                Cmd_Op    <= pend_op;
              end
            endcase
          end else if (tmo_expired) begin
            Frame_Error <= 1'b1;
            Err_Code    <= ERR_TIMEOUT;
            state       <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (Cmd_Ready) begin
            // Handshake completes; a byte arriving now opens the next frame
            Cmd_Valid <= 1'b0;
            state     <= ST_IDLE;
            if (Rx_D_VLD) begin
              if (opc_known(Rx_P_Data[7:0])) begin
                state   <= opc_next_state(Rx_P_Data[7:0]);
                pend_op <= opc_to_op(Rx_P_Data[7:0]);
              end else begin
                Frame_Error <= 1'b1;
                Err_Code    <= ERR_OPCODE;
              end
            end
          end else if (Rx_D_VLD) begin
            Frame_Error <= 1'b1;
            Err_Code    <= ERR_OVERRUN;
          end
        end
        default: begin
          state     <= ST_IDLE;
          Cmd_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
